// File: rtl/bsl_pkg.sv
// Shared types and the bitwise function table for the bit-serial logic unit.
package bsl_pkg;

  typedef enum logic [2:0] {
    FN_AND   = 3'b000,
    FN_OR    = 3'b001,
    FN_XOR   = 3'b010,
    FN_ONES  = 3'b011,
    FN_NAND  = 3'b100,
    FN_NOR   = 3'b101,
    FN_XNOR  = 3'b110,
    FN_ZEROS = 3'b111
  } func_e;

  typedef enum logic [1:0] {
    RT_KEEP = 2'b00,
    RT_TO_B = 2'b01,
    RT_TO_A = 2'b10,
    RT_SWAP = 2'b11
  } route_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_e;

  function automatic logic apply_func(func_e f, logic a, logic b);
    logic res;
    res = 1'b0;
    case (f)
      FN_AND:   res = a & b;
      FN_OR:    res = a | b;
      FN_XOR:   res = a ^ b;
      FN_ONES:  res = 1'b1;
      FN_NAND:  res = ~(a & b);
      FN_NOR:   res = ~(a | b);
      FN_XNOR:  res = ~(a ^ b);
      FN_ZEROS: res = 1'b0;
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bsl_lane_router.sv
// Computes one shift step's lane results and picks what gets inserted
// into the top bits of the A and B registers.
module bsl_lane_router
  import bsl_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic [LANES-1:0] a_lo,
  input  logic [LANES-1:0] b_lo,
  input  func_e            f,
  input  route_e           r,
  output logic [LANES-1:0] a_in,
  output logic [LANES-1:0] b_in
);

  logic [LANES-1:0] res;

  always_comb begin
    res = '0;
    for (int i = 0; i < LANES; i++) begin
      res[i] = apply_func(f, a_lo[i], b_lo[i]);
    end
  end

  // Unrouted registers recirculate their own low bits, so a full pass leaves them unchanged.
  always_comb begin
    a_in = a_lo;
    b_in = b_lo;
    case (r)
      RT_KEEP: begin
        a_in = a_lo;
        b_in = b_lo;
      end
      RT_TO_B: begin
        a_in = a_lo;
        b_in = res;
      end
      RT_TO_A: begin
        a_in = res;
        b_in = b_lo;
      end
      RT_SWAP: begin
        a_in = b_lo;
        b_in = a_lo;
      end
      default: begin
        a_in = a_lo;
        b_in = b_lo;
      end
    endcase
  end

endmodule

// File: rtl/bit_serial_logic_unit.sv
// Bit-serial logic unit: two operand registers, a run-once Execute trigger
// and a WIDTH/LANES-cycle shift that applies one of eight bitwise functions.
module bit_serial_logic_unit
  import bsl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 1,
  parameter int CNT_W = $clog2(WIDTH / LANES + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadA,
  input  logic             LoadB,
  input  logic             Execute,
  input  logic [WIDTH-1:0] Din,
  input  logic [2:0]       F,
  input  logic [1:0]       R,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Busy,
  output logic             Done
);

  localparam int               STEPS   = WIDTH / LANES;
  localparam logic [CNT_W-1:0] STEPS_C = CNT_W'(STEPS);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  if ((WIDTH % LANES) != 0) begin : g_bad_lanes
    $error("bit_serial_logic_unit: WIDTH must be a multiple of LANES");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] count_q, count_d;
  func_e            f_q, f_d;
  route_e           r_q, r_d;
  logic             exec_q;
  logic             done_q, done_d;
  logic             start;
  logic             busy;

  logic [LANES-1:0] a_in, b_in;
  logic [WIDTH-1:0] a_shift, b_shift;

  bsl_lane_router #(
    .LANES(LANES)
  ) u_router (
    .a_lo(a_q[LANES-1:0]),
    .b_lo(b_q[LANES-1:0]),
    .f   (f_q),
    .r   (r_q),
    .a_in(a_in),
    .b_in(b_in)
  );

  if (LANES == WIDTH) begin : g_full_shift
    assign a_shift = a_in;
    assign b_shift = b_in;
  end else begin : g_part_shift
    assign a_shift = {a_in, a_q[WIDTH-1:LANES]};
    assign b_shift = {b_in, b_q[WIDTH-1:LANES]};
  end

  // exec_q resets high so an Execute held through reset is not seen as a fresh press.
  assign start = (state_q == IDLE) && Execute && !exec_q && !LoadA && !LoadB;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      count_q <= '0;
      f_q     <= FN_AND;
      r_q     <= RT_KEEP;
      exec_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      count_q <= count_d;
      f_q     <= f_d;
      r_q     <= r_d;
      exec_q  <= Execute;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    f_d     = f_q;
    r_d     = r_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          count_d = STEPS_C;
          f_d     = func_e'(F);
          r_d     = route_e'(R);
        end
      end
      SHIFT: begin
        count_d = count_q - ONE_C;
        if (count_q == ONE_C) begin
          state_d = HOLD;
          done_d  = 1'b1;
        end
      end
      HOLD: begin
        if (!Execute) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Loads are only honoured outside SHIFT; during SHIFT both registers step.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (state_q == SHIFT) begin
      a_d = a_shift;
      b_d = b_shift;
    end else begin
      if (LoadA) a_d = Din;
      if (LoadB) b_d = Din;
    end
  end

  always_comb begin
    busy = (state_q == SHIFT);
    Busy = busy;
    Done = done_q;
    Aval = a_q;
    Bval = b_q;
  end

endmodule

// File: tb/tb_bit_serial_logic_unit.sv
// Self-checking bench: table-driven operations on an 8x1 and a 16x4 instance,
// plus hand-written sequences for hold, load-priority and reset corners.
module tb_bit_serial_logic_unit;

  typedef struct {
    int          which;
    logic        do_load;
    logic [15:0] load_a;
    logic [15:0] load_b;
    logic [2:0]  f;
    logic [1:0]  r;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        ld_a8, ld_b8, exec8, busy8, done8;
  logic [7:0]  din8, aval8, bval8;
  logic [2:0]  f8;
  logic [1:0]  r8;
  logic        ld_a16, ld_b16, exec16, busy16, done16;
  logic [15:0] din16, aval16, bval16;
  logic [2:0]  f16;
  logic [1:0]  r16;

  exp_t sb_q[$];
  vec_t vecs[10];
  int   compared   = 0;
  int   mismatched = 0;

  bit_serial_logic_unit #(.WIDTH(8), .LANES(1)) dut8 (
    .Clk(clk), .Reset(reset), .LoadA(ld_a8), .LoadB(ld_b8), .Execute(exec8),
    .Din(din8), .F(f8), .R(r8), .Aval(aval8), .Bval(bval8), .Busy(busy8), .Done(done8)
  );

  bit_serial_logic_unit #(.WIDTH(16), .LANES(4)) dut16 (
    .Clk(clk), .Reset(reset), .LoadA(ld_a16), .LoadB(ld_b16), .Execute(exec16),
    .Din(din16), .F(f16), .R(r16), .Aval(aval16), .Bval(bval16), .Busy(busy16), .Done(done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] getA(int which);
    return (which == 0) ? {8'h00, aval8} : aval16;
  endfunction

  function automatic logic [15:0] getB(int which);
    return (which == 0) ? {8'h00, bval8} : bval16;
  endfunction

  function automatic logic getBusy(int which);
    return (which == 0) ? busy8 : busy16;
  endfunction

  function automatic logic getDone(int which);
    return (which == 0) ? done8 : done16;
  endfunction

  task automatic setLoad(int which, logic la, logic lb, logic [15:0] din);
    if (which == 0) begin
      ld_a8 = la; ld_b8 = lb; din8 = din[7:0];
    end else begin
      ld_a16 = la; ld_b16 = lb; din16 = din;
    end
  endtask

  task automatic setExec(int which, logic v);
    if (which == 0) exec8 = v;
    else exec16 = v;
  endtask

  task automatic setFunc(int which, logic [2:0] f, logic [1:0] r);
    if (which == 0) begin
      f8 = f; r8 = r;
    end else begin
      f16 = f; r16 = r;
    end
  endtask

  task automatic loadBoth(int which, logic [15:0] a, logic [15:0] b);
    setLoad(which, 1'b1, 1'b0, a);
    tick();
    setLoad(which, 1'b0, 1'b1, b);
    tick();
    setLoad(which, 1'b0, 1'b0, 16'h0000);
    check($sformatf("load%0d_A", which), getA(which), a);
    check($sformatf("load%0d_B", which), getB(which), b);
  endtask

  // Push the expected result, then press Execute; returns just after the start edge.
  task automatic applyStimulus(int which, logic [2:0] f, logic [1:0] r,
                               logic [15:0] exp_a, logic [15:0] exp_b);
    exp_t e;
    e.a = exp_a;
    e.b = exp_b;
    sb_q.push_back(e);
    setFunc(which, f, r);
    setExec(which, 1'b1);
    tick();
  endtask

  // Waits for Done (bounded), checks Busy length and result, then releases Execute.
  task automatic checkOutput(int which, string name, int exp_busy);
    exp_t e;
    int   busy_cnt = 0;
    int   cycles   = 0;
    while (!getDone(which) && cycles < 40) begin
      if (getBusy(which)) busy_cnt++;
      tick();
      cycles++;
    end
    check({name, "_done"}, {15'd0, getDone(which)}, 16'd1);
    check({name, "_busy_cycles"}, 16'(busy_cnt), 16'(exp_busy));
    check({name, "_busy_low"}, {15'd0, getBusy(which)}, 16'd0);
    if (sb_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_scoreboard: got empty queue expected entry", name);
    end else begin
      e = sb_q.pop_front();
      check({name, "_A"}, getA(which), e.a);
      check({name, "_B"}, getB(which), e.b);
    end
    tick();
    check({name, "_done_pulse"}, {15'd0, getDone(which)}, 16'd0);
    setExec(which, 1'b0);
    tick();
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;

    vecs[0] = '{0, 1'b1, 16'h0033, 16'h0055, 3'b010, 2'b10, 16'h0066, 16'h0055};
    vecs[1] = '{0, 1'b0, 16'h0000, 16'h0000, 3'b110, 2'b01, 16'h0066, 16'h00CC};
    vecs[2] = '{0, 1'b0, 16'h0000, 16'h0000, 3'b000, 2'b11, 16'h00CC, 16'h0066};
    vecs[3] = '{0, 1'b0, 16'h0000, 16'h0000, 3'b101, 2'b00, 16'h00CC, 16'h0066};
    vecs[4] = '{1, 1'b1, 16'hF0F0, 16'hFF00, 3'b000, 2'b10, 16'hF000, 16'hFF00};
    vecs[5] = '{1, 1'b0, 16'h0000, 16'h0000, 3'b111, 2'b01, 16'hF000, 16'h0000};
    vecs[6] = '{0, 1'b1, 16'h000F, 16'h003C, 3'b100, 2'b10, 16'h00F3, 16'h003C};
    vecs[7] = '{0, 1'b0, 16'h0000, 16'h0000, 3'b011, 2'b01, 16'h00F3, 16'h00FF};
    vecs[8] = '{0, 1'b0, 16'h0000, 16'h0000, 3'b001, 2'b10, 16'h00FF, 16'h00FF};
    vecs[9] = '{0, 1'b1, 16'h00A0, 16'h0005, 3'b101, 2'b10, 16'h005A, 16'h0005};

    reset = 1'b1;
    setLoad(0, 1'b0, 1'b0, 16'h0000);
    setLoad(1, 1'b0, 1'b0, 16'h0000);
    setFunc(0, 3'b000, 2'b00);
    setFunc(1, 3'b000, 2'b00);
    setExec(0, 1'b1);
    setExec(1, 1'b1);
    tick();
    tick();
    for (int w = 0; w < 2; w++) begin
      check($sformatf("reset%0d_A", w), getA(w), 16'h0000);
      check($sformatf("reset%0d_B", w), getB(w), 16'h0000);
      check($sformatf("reset%0d_busy", w), {15'd0, getBusy(w)}, 16'd0);
      check($sformatf("reset%0d_done", w), {15'd0, getDone(w)}, 16'd0);
    end
    reset = 1'b0;
    tick();
    tick();
    check("exec_through_reset_busy8", {15'd0, busy8}, 16'd0);
    check("exec_through_reset_busy16", {15'd0, busy16}, 16'd0);
    setExec(0, 1'b0);
    setExec(1, 1'b0);
    tick();

    $display("[TB] table-driven operations");
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_load) loadBoth(vecs[i].which, vecs[i].load_a, vecs[i].load_b);
      applyStimulus(vecs[i].which, vecs[i].f, vecs[i].r, vecs[i].exp_a, vecs[i].exp_b);
      checkOutput(vecs[i].which, $sformatf("vec%0d", i), (vecs[i].which == 0) ? 8 : 4);
    end

    $display("[TB] Execute held high for 30 cycles");
    loadBoth(0, 16'h0033, 16'h0055);
    setFunc(0, 3'b010, 2'b10);
    exec8 = 1'b1;
    tick();
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (busy8) busy_cnt++;
      if (done8) done_cnt++;
      tick();
    end
    check("hold_busy_cycles", 16'(busy_cnt), 16'd8);
    check("hold_done_pulses", 16'(done_cnt), 16'd1);
    check("hold_A", {8'h00, aval8}, 16'h0066);
    check("hold_B", {8'h00, bval8}, 16'h0055);
    exec8 = 1'b0;
    tick();
    tick();
    applyStimulus(0, 3'b010, 2'b10, 16'h0033, 16'h0055);
    checkOutput(0, "repress", 8);

    $display("[TB] LoadA during SHIFT is ignored");
    loadBoth(0, 16'h0033, 16'h0055);
    applyStimulus(0, 3'b010, 2'b10, 16'h0066, 16'h0055);
    tick();
    ld_a8 = 1'b1;
    din8  = 8'hAA;
    tick();
    tick();
    ld_a8 = 1'b0;
    din8  = 8'h00;
    checkOutput(0, "load_in_shift", 5);

    $display("[TB] LoadA beats a simultaneous Execute edge");
    ld_a8 = 1'b1;
    din8  = 8'hAA;
    exec8 = 1'b1;
    tick();
    ld_a8 = 1'b0;
    din8  = 8'h00;
    check("prio_A", {8'h00, aval8}, 16'h00AA);
    check("prio_busy0", {15'd0, busy8}, 16'd0);
    tick();
    tick();
    check("prio_busy1", {15'd0, busy8}, 16'd0);
    check("prio_A_kept", {8'h00, aval8}, 16'h00AA);
    exec8 = 1'b0;
    tick();

    $display("[TB] reset in the middle of SHIFT");
    loadBoth(0, 16'h0033, 16'h0055);
    setFunc(0, 3'b010, 2'b10);
    exec8 = 1'b1;
    tick();
    tick();
    tick();
    check("pre_reset_busy", {15'd0, busy8}, 16'd1);
    reset = 1'b1;
    tick();
    check("mid_reset_A", {8'h00, aval8}, 16'h0000);
    check("mid_reset_B", {8'h00, bval8}, 16'h0000);
    check("mid_reset_busy", {15'd0, busy8}, 16'd0);
    check("mid_reset_done", {15'd0, done8}, 16'd0);
    reset = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (busy8) busy_cnt++;
      if (done8) done_cnt++;
    end
    check("post_reset_no_busy", 16'(busy_cnt), 16'd0);
    check("post_reset_no_done", 16'(done_cnt), 16'd0);
    exec8 = 1'b0;
    tick();
    applyStimulus(0, 3'b011, 2'b10, 16'h00FF, 16'h0000);
    checkOutput(0, "post_reset_run", 8);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
